// File: rtl/tile_result_collector.sv
// -----------------------------------------------------------------------------
// tile_result_collector
//
// Drains NUM_TILES tile result FIFOs (registered read, 1-cycle latency) in
// round-robin order and packs up to PACK results of one tile into a single
// wide output word. One packed word is produced per grant. A level flush input
// lets a partially filled word go out once the granted tile runs dry.
//
// Ports
//   i_clk            single clock
//   i_reset_n        asynchronous active-low reset
//   i_tile_rd_data   FIFO read data, tile t in [t*DATA_WIDTH +: DATA_WIDTH]
//   i_tile_empty     FIFO empty flags
//   o_tile_rd_en     FIFO read strobes, at most one bit high (combinational)
//   i_flush          allow a partial word when the granted tile is empty
//   o_data           packed results, first read in lane 0, unused lanes zero
//   o_tile_id        source tile of o_data
//   o_lanes          number of valid lanes (1..PACK)
//   o_valid/i_ready  output handshake
//   o_busy           FSM active or an output word pending
//
// State table
//   state  | meaning
//   IDLE   | round-robin scan for a non-empty tile, clear pack register
//   READ   | strobe the granted FIFO until PACK reads or flush on empty
//   WAIT   | let the last in-flight read data land in the pack register
//   PUSH   | move the pack register to the output once the slot is free
// -----------------------------------------------------------------------------
module tile_result_collector #(
    parameter int NUM_TILES  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PACK       = 8,
    localparam int OUT_W     = DATA_WIDTH * PACK,
    localparam int ID_W      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int LW        = $clog2(PACK + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_TILES*DATA_WIDTH-1:0] i_tile_rd_data,
    input  logic [NUM_TILES-1:0]            i_tile_empty,
    output logic [NUM_TILES-1:0]            o_tile_rd_en,
    input  logic                            i_flush,
    output logic [OUT_W-1:0]                o_data,
    output logic [ID_W-1:0]                 o_tile_id,
    output logic [LW-1:0]                   o_lanes,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_PUSH = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]   grant_q,    grant_d;
    logic [LW-1:0]     issued_q,   issued_d;
    logic [LW-1:0]     fill_q,     fill_d;
    logic              cap_pend_q, cap_pend_d;
    logic [OUT_W-1:0]  pack_q,     pack_d;
    logic [OUT_W-1:0]  data_q,     data_d;
    logic [ID_W-1:0]   tile_id_q,  tile_id_d;
    logic [LW-1:0]     lanes_q,    lanes_d;
    logic              valid_q,    valid_d;

    logic [NUM_TILES-1:0]  rd_en;
    logic                  strobe;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  scan_hit;
    logic [ID_W-1:0]       scan_idx;
    logic [ID_W:0]         cand_sum;
    logic [ID_W-1:0]       grant_next;

    // Read strobe and read-data mux for the granted tile.
    always_comb begin
        rd_en    = '0;
        sel_data = '0;
        for (int t = 0; t < NUM_TILES; t++) begin
            if (grant_q == ID_W'(t)) begin
                sel_data = i_tile_rd_data[t*DATA_WIDTH +: DATA_WIDTH];
                rd_en[t] = (state_q == S_READ) && !i_tile_empty[t];
            end
        end
    end

    assign strobe       = |rd_en;
    assign o_tile_rd_en = rd_en;

    // Round-robin scan starting at rr_ptr; the sum is one bit wider so the
    // modulo wrap also works for non power-of-two tile counts.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = rr_ptr_q;
        cand_sum = '0;
        for (int k = 0; k < NUM_TILES; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand_sum >= (ID_W+1)'(NUM_TILES)) begin
                cand_sum = cand_sum - (ID_W+1)'(NUM_TILES);
            end
            if (!scan_hit && !i_tile_empty[cand_sum[ID_W-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = cand_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        if (grant_q == ID_W'(NUM_TILES - 1)) begin
            grant_next = '0;
        end else begin
            grant_next = grant_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        issued_d   = issued_q;
        fill_d     = fill_q;
        pack_d     = pack_q;
        data_d     = data_q;
        tile_id_d  = tile_id_q;
        lanes_d    = lanes_q;
        cap_pend_d = strobe;
        // An accepted word frees the slot unless PUSH reloads it below.
        valid_d    = valid_q && !i_ready;

        // Data strobed last cycle is on the FIFO output now.
        if (cap_pend_q) begin
            for (int l = 0; l < PACK; l++) begin
                if (fill_q == LW'(l)) begin
                    pack_d[l*DATA_WIDTH +: DATA_WIDTH] = sel_data;
                end
            end
            fill_d = fill_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (scan_hit) begin
                    grant_d  = scan_idx;
                    issued_d = '0;
                    fill_d   = '0;
                    pack_d   = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (strobe) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q == LW'(PACK - 1)) begin
                        state_d = S_WAIT;
                    end
                end else if ((issued_q != '0) && i_flush) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_PUSH;
            end
            S_PUSH: begin
                if (!valid_q || i_ready) begin
                    data_d    = pack_q;
                    tile_id_d = grant_q;
                    lanes_d   = fill_q;
                    valid_d   = 1'b1;
                    rr_ptr_d  = grant_next;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            issued_q   <= '0;
            fill_q     <= '0;
            cap_pend_q <= 1'b0;
            pack_q     <= '0;
            data_q     <= '0;
            tile_id_q  <= '0;
            lanes_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            issued_q   <= issued_d;
            fill_q     <= fill_d;
            cap_pend_q <= cap_pend_d;
            pack_q     <= pack_d;
            data_q     <= data_d;
            tile_id_q  <= tile_id_d;
            lanes_q    <= lanes_d;
            valid_q    <= valid_d;
        end
    end

    assign o_data    = data_q;
    assign o_tile_id = tile_id_q;
    assign o_lanes   = lanes_q;
    assign o_valid   = valid_q;
    assign o_busy    = (state_q != S_IDLE) || valid_q;

endmodule

// File: tb/tb_tile_result_collector.sv
// -----------------------------------------------------------------------------
// tb_tile_result_collector
//
// Bench for tile_result_collector. Models the tile FIFOs as queues with a
// registered read port, keeps a per-tile scoreboard of pushed results and
// checks every accepted word lane by lane against it, plus table vectors and
// directed sequences for latency, round-robin, flush, backpressure, gaps and
// reset.
// -----------------------------------------------------------------------------
module tb_tile_result_collector;

    localparam int NT    = 4;
    localparam int DW    = 16;
    localparam int PK    = 8;
    localparam int OUT_W = DW * PK;
    localparam int ID_W  = 2;
    localparam int LW    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NT*DW-1:0]  rd_data;
    logic [NT-1:0]     empty;
    logic [NT-1:0]     rd_en;
    logic              flush;
    logic [OUT_W-1:0]  o_data;
    logic [ID_W-1:0]   o_tile_id;
    logic [LW-1:0]     o_lanes;
    logic              o_valid;
    logic              ready;
    logic              busy;

    always #5 clk = ~clk;

    tile_result_collector #(
        .NUM_TILES (NT),
        .DATA_WIDTH(DW),
        .PACK      (PK)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_tile_rd_data(rd_data),
        .i_tile_empty  (empty),
        .o_tile_rd_en  (rd_en),
        .i_flush       (flush),
        .o_data        (o_data),
        .o_tile_id     (o_tile_id),
        .o_lanes       (o_lanes),
        .o_valid       (o_valid),
        .i_ready       (ready),
        .o_busy        (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0]    fq  [NT][$];
    logic [DW-1:0]    exq [NT][$];
    logic [NT-1:0]    rd_en_s;
    int               strobes [NT];
    int               log_id [$];
    int               log_lanes [$];
    logic [OUT_W-1:0] log_data [$];
    int               words;
    int               first_valid;

    logic             prev_hold;
    logic [OUT_W-1:0] prev_data;
    logic [ID_W-1:0]  prev_id;
    logic [LW-1:0]    prev_lanes;

    typedef struct {
        int          tile;
        int          cnt;
        bit          fl;
        logic [15:0] base;
        int          exp_id;
        int          exp_lanes;
    } vec_t;

    vec_t vt [6];

    task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int t, input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fq[t].push_back(16'(base + 16'(i)));
            exq[t].push_back(16'(base + 16'(i)));
        end
    endtask

    task automatic fifo_update();
        for (int t = 0; t < NT; t++) begin
            if (rd_en_s[t] && fq[t].size() > 0) begin
                rd_data[t*DW +: DW] = fq[t].pop_front();
            end
            empty[t] = (fq[t].size() == 0);
        end
    endtask

    task automatic score_word();
        int t;
        int n;
        logic [DW-1:0] lane;
        t = int'(o_tile_id);
        n = int'(o_lanes);
        chk_eq("word_lanes_range", (n >= 1 && n <= PK), 1);
        for (int l = 0; l < PK; l++) begin
            lane = o_data[l*DW +: DW];
            if (l < n) begin
                if (exq[t].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word_extra_lane tile=%0d lane=%0d actual=%0h required=none", t, l, lane);
                end else begin
                    chk_eq("word_lane_data", lane, exq[t].pop_front());
                end
            end else begin
                chk_eq("word_pad_zero", lane, 0);
            end
        end
        log_id.push_back(t);
        log_lanes.push_back(n);
        log_data.push_back(o_data);
        words++;
    endtask

    task automatic monitor();
        rd_en_s = rd_en;
        if (rd_en != '0) begin
            chk_eq("rd_en_onehot", $onehot(rd_en), 1);
            chk_eq("rd_en_while_empty", |(rd_en & empty), 0);
            for (int t = 0; t < NT; t++) begin
                if (rd_en[t]) strobes[t]++;
            end
        end
        if (prev_hold) begin
            chk_eq("hold_valid", o_valid, 1);
            chk_eq("hold_data", o_data, prev_data);
            chk_eq("hold_tile_id", o_tile_id, prev_id);
            chk_eq("hold_lanes", o_lanes, prev_lanes);
        end
        if (o_valid && first_valid < 0) first_valid = cyc;
        if (rst_n && o_valid && ready) score_word();
        prev_hold  = rst_n && o_valid && !ready;
        prev_data  = o_data;
        prev_id    = o_tile_id;
        prev_lanes = o_lanes;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        fifo_update();
    endtask

    task automatic clear_logs();
        for (int t = 0; t < NT; t++) strobes[t] = 0;
        log_id.delete();
        log_lanes.delete();
        log_data.delete();
        words       = 0;
        first_valid = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int t = 0; t < NT; t++) begin
            fq[t].delete();
            exq[t].delete();
        end
        rd_data   = '0;
        empty     = '1;
        rd_en_s   = '0;
        prev_hold = 1'b0;
        #1;
        chk_eq("rst_valid", o_valid, 0);
        chk_eq("rst_data", o_data, 0);
        chk_eq("rst_tile_id", o_tile_id, 0);
        chk_eq("rst_lanes", o_lanes, 0);
        chk_eq("rst_rd_en", rd_en, 0);
        chk_eq("rst_busy", busy, 0);
        repeat (2) step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (words < n && b < budget) begin
            step();
            b++;
        end
        chk_eq(name, (words >= n), 1);
    endtask

    initial begin
        int c0;
        int w;
        int pending;
        int b;

        vt[0] = '{0, 8, 1'b0, 16'h1000, 0, 8};
        vt[1] = '{2, 3, 1'b1, 16'h2000, 2, 3};
        vt[2] = '{1, 1, 1'b1, 16'h3000, 1, 1};
        vt[3] = '{3, 8, 1'b1, 16'h4000, 3, 8};
        vt[4] = '{1, 7, 1'b1, 16'h5000, 1, 7};
        vt[5] = '{3, 4, 1'b1, 16'h6000, 3, 4};

        rst_n   = 1'b1;
        ready   = 1'b1;
        flush   = 1'b0;
        empty   = '1;
        rd_data = '0;
        rd_en_s = '0;
        #1;
        do_reset();

        // Single full word from tile 0: latency and strobe count.
        push(0, 8, 16'h3C00);
        step();
        c0 = cyc;
        first_valid = -1;
        wait_words(1, 40, "t1_timeout");
        chk_eq("t1_latency", first_valid - c0, 11);
        chk_eq("t1_strobes", strobes[0], 8);
        if (words >= 1) begin
            chk_eq("t1_tile_id", log_id[0], 0);
            chk_eq("t1_lanes", log_lanes[0], 8);
            chk_eq("t1_lane0", log_data[0][15:0], 16'h3C00);
            chk_eq("t1_lane7", log_data[0][127:112], 16'h3C07);
        end

        // Table vectors, one non-empty tile each.
        for (int i = 0; i < 6; i++) begin
            flush = vt[i].fl;
            w = words;
            push(vt[i].tile, vt[i].cnt, vt[i].base);
            wait_words(w + 1, 60, "vec_timeout");
            if (words > w) begin
                chk_eq("vec_tile_id", log_id[w], vt[i].exp_id);
                chk_eq("vec_lanes", log_lanes[w], vt[i].exp_lanes);
                chk_eq("vec_lane0", log_data[w][15:0], vt[i].base);
            end
            flush = 1'b0;
            repeat (3) step();
            chk_eq("vec_busy_idle", busy, 0);
        end

        // Round-robin across four full tiles.
        do_reset();
        for (int t = 0; t < NT; t++) push(t, 16, 16'((t + 1) * 16'h0100));
        wait_words(8, 200, "rr_timeout");
        for (int i = 0; i < 8 && i < words; i++) begin
            chk_eq("rr_order", log_id[i], i % NT);
            chk_eq("rr_lanes", log_lanes[i], 8);
        end
        for (int t = 0; t < NT; t++) chk_eq("rr_strobes", strobes[t], 16);

        // Flush partial word from tile 2, then round-robin resumes at tile 3.
        do_reset();
        flush = 1'b1;
        push(2, 3, 16'h7000);
        wait_words(1, 60, "fl_timeout");
        if (words >= 1) begin
            chk_eq("fl_tile_id", log_id[0], 2);
            chk_eq("fl_lanes", log_lanes[0], 3);
            chk_eq("fl_upper_zero", log_data[0][127:48], 0);
        end
        flush = 1'b0;
        push(0, 8, 16'h7100);
        push(3, 8, 16'h7300);
        wait_words(3, 80, "fl_rr_timeout");
        if (words >= 3) begin
            chk_eq("fl_rr_next", log_id[1], 3);
            chk_eq("fl_rr_after", log_id[2], 0);
        end

        // Backpressure with two full tiles.
        do_reset();
        ready = 1'b0;
        push(0, 8, 16'hB000);
        push(1, 8, 16'hB100);
        repeat (25) step();
        chk_eq("bp_no_transfer", words, 0);
        chk_eq("bp_valid_held", o_valid, 1);
        chk_eq("bp_tile_id", o_tile_id, 0);
        chk_eq("bp_second_read", strobes[1], 8);
        chk_eq("bp_busy", busy, 1);
        ready = 1'b1;
        wait_words(2, 20, "bp_timeout");
        if (words >= 2) begin
            chk_eq("bp_first", log_id[0], 0);
            chk_eq("bp_second", log_id[1], 1);
        end
        chk_eq("bp_no_overrun", strobes[1], 8);

        // Gap mid-word without flush: one 8-lane word.
        do_reset();
        push(1, 5, 16'h8000);
        repeat (15) step();
        chk_eq("gap_strobes", strobes[1], 5);
        chk_eq("gap_no_valid", o_valid, 0);
        chk_eq("gap_busy", busy, 1);
        push(1, 3, 16'h8005);
        wait_words(1, 40, "gap_timeout");
        if (words >= 1) begin
            chk_eq("gap_tile_id", log_id[0], 1);
            chk_eq("gap_lanes", log_lanes[0], 8);
        end
        chk_eq("gap_total_strobes", strobes[1], 8);

        // Reset in the middle of READ.
        do_reset();
        push(0, 8, 16'h9000);
        b = 0;
        while (strobes[0] < 4 && b < 30) begin
            step();
            b++;
        end
        chk_eq("mr_strobes", strobes[0], 4);
        do_reset();
        push(2, 8, 16'hA000);
        wait_words(1, 40, "mr_timeout");
        if (words >= 1) begin
            chk_eq("mr_tile_id", log_id[0], 2);
            chk_eq("mr_lane0", log_data[0][15:0], 16'hA000);
        end
        repeat (3) step();
        chk_eq("mr_single_word", words, 1);

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                push($urandom_range(0, NT - 1), $urandom_range(1, 6), 16'($urandom));
            end
            ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        flush   = 1'b1;
        ready   = 1'b1;
        pending = 1;
        b       = 0;
        while ((pending > 0 || busy) && b < 4000) begin
            step();
            b++;
            pending = 0;
            for (int t = 0; t < NT; t++) pending += exq[t].size();
        end
        chk_eq("rand_drained", pending, 0);
        chk_eq("rand_idle", busy, 0);
        chk_eq("rand_words", (words > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
